// File: rtl/gpio_tmr_fault_manager.sv
// Majority voter plus persistent-fault detection and one-at-a-time resync sequencing for triplicated GPIO.
// Optional input fault injection is enabled by defining TMR_FAULT_INJECT_EN.
module gpio_tmr_fault_manager #(
  parameter int WIDTH       = 8,
  parameter int PERSIST     = 4,
  parameter int CNT_W       = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int SETTLE      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_a,
  input  logic [WIDTH-1:0] gpio_b,
  input  logic [WIDTH-1:0] gpio_c,
  input  logic             clr_cnt,
  input  logic [2:0]       resync_ack,
`ifdef TMR_FAULT_INJECT_EN
  input  logic [2:0]       inj_en,
  input  logic [WIDTH-1:0] inj_mask,
`endif
  output logic [WIDTH-1:0] gpio_voted,
  output logic [2:0]       mismatch,
  output logic [2:0]       fault,
  output logic [2:0]       dead,
  output logic             multi_fault,
  output logic [2:0]       resync_req,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  localparam int PW   = $clog2(PERSIST + 1);
  localparam int TMAX = (ACK_TIMEOUT > SETTLE) ? ACK_TIMEOUT : SETTLE;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RELEASE, S_SETTLE, S_CHECK} state_t;

  logic [WIDTH-1:0] w_in [3];
  logic [WIDTH-1:0] w_vote;
  logic [WIDTH-1:0] r_voted;
  logic [2:0]       r_mismatch;
  logic             r_multi;
  logic [2:0]       w_fault;
  logic [2:0]       w_dead;
  logic [2:0]       w_cand;
  logic [CNT_W-1:0] w_err [3];

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_target;
  logic [1:0]       w_target_next;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_next;
  logic [2:0]       w_req;
  logic [2:0]       w_hold;
  logic [2:0]       w_set_dead;
  logic [2:0]       w_clr_fault;

`ifdef TMR_FAULT_INJECT_EN
  assign w_in[0] = inj_en[0] ? (gpio_a ^ inj_mask) : gpio_a;
  assign w_in[1] = inj_en[1] ? (gpio_b ^ inj_mask) : gpio_b;
  assign w_in[2] = inj_en[2] ? (gpio_c ^ inj_mask) : gpio_c;
`else
  assign w_in[0] = gpio_a;
  assign w_in[1] = gpio_b;
  assign w_in[2] = gpio_c;
`endif

  assign w_vote = (w_in[0] & w_in[1]) | (w_in[1] & w_in[2]) | (w_in[0] & w_in[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_voted    <= '0;
      r_mismatch <= '0;
      r_multi    <= 1'b0;
    end else begin
      r_voted    <= w_vote;
      r_mismatch <= {|(w_in[2] ^ w_vote), |(w_in[1] ^ w_vote), |(w_in[0] ^ w_vote)};
      // Two or more of three flags set is the majority of (fault|dead).
      r_multi    <= ((w_fault[0] | w_dead[0]) & (w_fault[1] | w_dead[1]))
                  | ((w_fault[1] | w_dead[1]) & (w_fault[2] | w_dead[2]))
                  | ((w_fault[0] | w_dead[0]) & (w_fault[2] | w_dead[2]));
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    logic [PW-1:0]    r_pers;
    logic [CNT_W-1:0] r_err;
    logic             r_flt;
    logic             r_dead;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pers <= '0;
        r_err  <= '0;
        r_flt  <= 1'b0;
        r_dead <= 1'b0;
      end else begin
        if (clr_cnt)
          r_err <= '0;
        else if (r_mismatch[gi] && (r_err != '1))
          r_err <= r_err + 1'b1;

        if (w_hold[gi])
          r_pers <= '0;
        else if (!r_dead) begin
          if (!r_mismatch[gi])
            r_pers <= '0;
          else if (r_pers != PW'(PERSIST))
            r_pers <= r_pers + 1'b1;
        end

        // The CHECK verdict wins over a fault raised in the same cycle.
        if (w_clr_fault[gi])
          r_flt <= 1'b0;
        else if (!w_hold[gi] && !r_dead && r_mismatch[gi] && (r_pers == PW'(PERSIST - 1)))
          r_flt <= 1'b1;

        if (w_set_dead[gi])
          r_dead <= 1'b1;
      end
    end

    assign w_fault[gi] = r_flt;
    assign w_dead[gi]  = r_dead;
    assign w_err[gi]   = r_err;
  end

  assign w_cand = w_fault & ~w_dead;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_target <= 2'd0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_target <= w_target_next;
      r_timer  <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_target_next = r_target;
    w_timer_next  = r_timer;
    w_req         = '0;
    w_hold        = '0;
    w_set_dead    = '0;
    w_clr_fault   = '0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        if (w_cand[0]) begin
          w_target_next = 2'd0;
          w_state_next  = S_REQ;
        end else if (w_cand[1]) begin
          w_target_next = 2'd1;
          w_state_next  = S_REQ;
        end else if (w_cand[2]) begin
          w_target_next = 2'd2;
          w_state_next  = S_REQ;
        end
      end
      S_REQ: begin
        w_req[r_target] = 1'b1;
        if (resync_ack[r_target]) begin
          w_timer_next = '0;
          w_state_next = S_RELEASE;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_set_dead[r_target] = 1'b1;
          w_state_next         = S_IDLE;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!resync_ack[r_target]) begin
          w_timer_next = '0;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_hold[r_target] = 1'b1;
        if (r_timer == TW'(SETTLE - 1))
          w_state_next = S_CHECK;
        else
          w_timer_next = r_timer + 1'b1;
      end
      S_CHECK: begin
        if (r_mismatch[r_target])
          w_set_dead[r_target] = 1'b1;
        else
          w_clr_fault[r_target] = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign gpio_voted  = r_voted;
  assign mismatch    = r_mismatch;
  assign fault       = w_fault;
  assign dead        = w_dead;
  assign multi_fault = r_multi;
  assign resync_req  = w_req;
  assign busy        = (r_state != S_IDLE);
  assign err_cnt_a   = w_err[0];
  assign err_cnt_b   = w_err[1];
  assign err_cnt_c   = w_err[2];

endmodule

// File: tb/tb_gpio_tmr_fault_manager.sv
// Randomized and directed bench for gpio_tmr_fault_manager against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_gpio_tmr_fault_manager;
  localparam int WIDTH       = 8;
  localparam int PERSIST     = 4;
  localparam int CNT_W       = 6;
  localparam int ACK_TIMEOUT = 64;
  localparam int SETTLE      = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] gpio_a, gpio_b, gpio_c;
  logic             clr_cnt;
  logic [2:0]       resync_ack;
  logic [WIDTH-1:0] gpio_voted;
  logic [2:0]       mismatch, fault, dead, resync_req;
  logic             multi_fault, busy;
  logic [CNT_W-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

  always #5 clk = ~clk;

  gpio_tmr_fault_manager #(
    .WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(CNT_W),
    .ACK_TIMEOUT(ACK_TIMEOUT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .gpio_a(gpio_a), .gpio_b(gpio_b), .gpio_c(gpio_c),
    .clr_cnt(clr_cnt), .resync_ack(resync_ack),
    .gpio_voted(gpio_voted), .mismatch(mismatch), .fault(fault), .dead(dead),
    .multi_fault(multi_fault), .resync_req(resync_req), .busy(busy),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 request up, 2 wait release, 3 settling, 4 verdict
  logic [WIDTH-1:0] m_voted;
  bit [2:0]         m_mis, m_fault, m_dead;
  bit               m_multi;
  int               m_pers [3];
  int               m_err  [3];
  int               m_phase, m_tgt, m_age;

  task automatic model_step();
    logic [WIDTH-1:0] iv [3];
    logic [WIDTH-1:0] vote;
    bit [2:0] hold, kill, clear;
    bit found, reached;
    int ones;
    iv[0] = gpio_a; iv[1] = gpio_b; iv[2] = gpio_c;
    if (rst) begin
      m_voted = '0; m_mis = '0; m_fault = '0; m_dead = '0; m_multi = 0;
      for (int x = 0; x < 3; x++) begin m_pers[x] = 0; m_err[x] = 0; end
      m_phase = 0; m_tgt = -1; m_age = 0;
      return;
    end
    for (int k = 0; k < WIDTH; k++) begin
      ones = 0;
      for (int x = 0; x < 3; x++) ones += int'(iv[x][k]);
      vote[k] = (ones >= 2);
    end
    hold = '0; kill = '0; clear = '0;
    case (m_phase)
      0: begin
        found = 0;
        for (int x = 0; x < 3; x++)
          if (!found && m_fault[x] && !m_dead[x]) begin
            found = 1; m_tgt = x; m_phase = 1; m_age = 0;
          end
      end
      1: begin
        if (resync_ack[m_tgt]) m_phase = 2;
        else begin
          m_age++;
          if (m_age == ACK_TIMEOUT) begin
            kill[m_tgt] = 1; m_phase = 0;
            $display("txn: resync inst %0d timed out -> dead (t=%0t)", m_tgt, $time);
          end
        end
      end
      2: if (!resync_ack[m_tgt]) begin m_phase = 3; m_age = 0; end
      3: begin
        hold[m_tgt] = 1;
        m_age++;
        if (m_age == SETTLE) m_phase = 4;
      end
      default: begin
        if (m_mis[m_tgt]) kill[m_tgt] = 1; else clear[m_tgt] = 1;
        $display("txn: resync inst %0d verdict %s (t=%0t)", m_tgt,
                 m_mis[m_tgt] ? "dead" : "recovered", $time);
        m_phase = 0;
      end
    endcase
    m_multi = ($countones(m_fault | m_dead) >= 2);
    for (int x = 0; x < 3; x++) begin
      if (clr_cnt) m_err[x] = 0;
      else if (m_mis[x] && m_err[x] < CNT_MAX) m_err[x]++;
      reached = 0;
      if (hold[x]) m_pers[x] = 0;
      else if (!m_dead[x]) begin
        if (!m_mis[x]) m_pers[x] = 0;
        else if (m_pers[x] < PERSIST) begin
          m_pers[x]++;
          reached = (m_pers[x] == PERSIST);
        end
      end
      if (clear[x]) m_fault[x] = 0;
      else if (reached) m_fault[x] = 1;
      if (kill[x]) m_dead[x] = 1;
    end
    for (int x = 0; x < 3; x++) m_mis[x] = (iv[x] != vote);
    m_voted = vote;
  endtask

  task automatic compare_all();
    bit [2:0] exp_req;
    exp_req = (m_phase == 1) ? 3'(1 << m_tgt) : 3'b000;
    check_val("voted", 64'(gpio_voted), 64'(m_voted));
    check_val("mismatch", 64'(mismatch), 64'(m_mis));
    check_val("fault", 64'(fault), 64'(m_fault));
    check_val("dead", 64'(dead), 64'(m_dead));
    check_val("multi_fault", 64'(multi_fault), 64'(m_multi));
    check_val("resync_req", 64'(resync_req), 64'(exp_req));
    check_val("busy", 64'(busy), 64'(m_phase != 0));
    check_val("err_cnt_a", 64'(err_cnt_a), 64'(m_err[0]));
    check_val("err_cnt_b", 64'(err_cnt_b), 64'(m_err[1]));
    check_val("err_cnt_c", 64'(err_cnt_c), 64'(m_err[2]));
  endtask

  // Ack responder driven from the model's view of the handshake
  int rsp_ack_dly, rsp_rel_dly, rsp_cnt, rsp_rel_cnt;
  bit rsp_never, rsp_rand, rsp_noise;

  task automatic drive_ack();
    bit [2:0] a;
    a = '0;
    if (m_phase == 1) begin
      if (!rsp_never && rsp_cnt >= rsp_ack_dly) a[m_tgt] = 1'b1;
      rsp_cnt++;
    end else if (m_phase == 2) begin
      if (rsp_rel_cnt < rsp_rel_dly) a[m_tgt] = 1'b1;
      rsp_rel_cnt++;
    end else begin
      rsp_cnt = 0; rsp_rel_cnt = 0;
      if (rsp_rand) begin
        rsp_ack_dly = $urandom_range(0, 8);
        rsp_rel_dly = $urandom_range(0, 4);
        rsp_never   = ($urandom_range(0, 9) == 0);
      end
    end
    if (rsp_noise && $urandom_range(0, 3) == 0) begin
      if (m_phase == 1 || m_phase == 2) a |= 3'($urandom_range(0, 7)) & ~3'(1 << m_tgt);
      else a = 3'($urandom_range(0, 7));
    end
    resync_ack = a;
  endtask

  task automatic tick();
    drive_ack();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    gpio_a = a; gpio_b = b; gpio_c = c;
  endtask

  int bad_left [3];

  task automatic rand_inputs();
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] v [3];
    base = WIDTH'($urandom);
    for (int x = 0; x < 3; x++) begin
      if (bad_left[x] == 0 && $urandom_range(0, 99) < 3)
        bad_left[x] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 7);
      v[x] = base;
      if (bad_left[x] > 0) begin
        v[x] = base ^ WIDTH'($urandom_range(1, 255));
        bad_left[x]--;
      end
    end
    set_in(v[0], v[1], v[2]);
    clr_cnt = ($urandom_range(0, 99) < 2);
    rst     = ($urandom_range(0, 999) < 3);
  endtask

  bit seen_multi;

  initial begin
    rst = 1'b1; clr_cnt = 1'b0; resync_ack = '0;
    set_in('0, '0, '0);
    rsp_ack_dly = 5; rsp_rel_dly = 2; rsp_never = 0; rsp_rand = 0; rsp_noise = 0;
    rsp_cnt = 0; rsp_rel_cnt = 0;
    for (int x = 0; x < 3; x++) bad_left[x] = 0;
    m_phase = 0; m_tgt = -1; m_age = 0;
    tick(); tick();
    check_val("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    set_in(8'h5A, 8'h5A, 8'h5A);
    repeat (20) tick();
    check_val("eq_voted", 64'(gpio_voted), 64'h5A);

    set_in(8'h00, 8'hFF, 8'h00);
    repeat (3) tick();
    set_in(8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    check_val("b_err3", 64'(err_cnt_b), 64'd3);
    check_val("b_nofault", 64'(fault), 64'd0);

    set_in(8'h3C, 8'h3C, 8'hC3);
    repeat (4) tick();
    set_in(8'h3C, 8'h3C, 8'h3C);
    repeat (40) tick();
    check_val("c_recovered", 64'(fault), 64'd0);
    check_val("c_not_dead", 64'(dead), 64'd0);

    rsp_never = 1;
    set_in(8'h55, 8'hAA, 8'hAA);
    repeat (80) tick();
    check_val("a_dead", 64'(dead[0]), 64'd1);
    check_val("a_err_sat", 64'(err_cnt_a), 64'(CNT_MAX));
    rsp_never = 0;

    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ack_dly = 2; rsp_rel_dly = 1;
    seen_multi = 0;
    set_in(8'h01, 8'h00, 8'h02);
    repeat (5) begin tick(); if (multi_fault) seen_multi = 1; end
    set_in(8'h00, 8'h00, 8'h00);
    repeat (90) begin tick(); if (multi_fault) seen_multi = 1; end
    check_val("ac_multi_seen", 64'(seen_multi), 64'd1);
    check_val("ac_recovered", 64'(fault | dead), 64'd0);

    rsp_never = 1;
    set_in(8'h00, 8'h00, 8'h80);
    for (int i = 0; i < 50 && m_phase != 1; i++) tick();
    repeat (3) tick();
    check_val("c_in_req", 64'(resync_req), 64'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("rst_req", 64'(resync_req), 64'd0);
    check_val("rst_fault", 64'(fault), 64'd0);
    check_val("rst_errc", 64'(err_cnt_c), 64'd0);
    rsp_never = 0;

    tick(); tick();
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    check_val("clr_vs_inc", 64'(err_cnt_c), 64'd0);
    set_in(8'h00, 8'h00, 8'h00);
    repeat (60) tick();

    rsp_rand = 1; rsp_noise = 1;
    repeat (5000) begin rand_inputs(); tick(); end
    rst = 1'b0; clr_cnt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
